// File: rtl/icache_inv_queue.sv
// icache_inv_queue
//   Buffers word-addressed I-cache invalidation requests from a ready/valid
//   source and replays them one at a time to the I-cache. Each replay is a
//   one-cycle out_inv_valid pulse, and the cache answers with a one-cycle
//   out_inv_completed pulse. The head entry stays queued until it completes,
//   so in_inv_outstanding covers the in-flight request as well.
//
//   Optional feature: define ICACHE_INV_QUEUE_MERGE_EN to drop an incoming
//   request whose address already sits in the queue. Once the head has been
//   issued it is excluded from this match.
//
// Ports
//   clk                 clock, all state on rising edge
//   rst_n               asynchronous active-low reset
//   in_inv_addr[29:0]   word address [31:2] to invalidate
//   in_inv_valid        upstream request valid
//   in_inv_ready        queue can accept (transfer on valid & ready)
//   in_inv_outstanding  any accepted invalidation not yet completed
//   out_inv_addr[29:0]  address of the request in flight
//   out_inv_valid       one-cycle issue pulse
//   out_inv_completed   downstream completion pulse
//
// state     | meaning
// ST_IDLE   | nothing in flight; load head when queue non-empty
// ST_REQ    | issue pulse cycle for out_inv_addr
// ST_WAIT   | request issued, waiting for out_inv_completed
module icache_inv_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [29:0] in_inv_addr,
  input  logic        in_inv_valid,
  output logic        in_inv_ready,
  output logic        in_inv_outstanding,
  output logic [29:0] out_inv_addr,
  output logic        out_inv_valid,
  input  logic        out_inv_completed
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  logic [29:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [1:0]       state_q, state_d;
  logic [29:0]      out_addr_q, out_addr_d;
  logic             merge_hit;
  logic             push;
  logic             pop;

  // Ready depends only on the registered count; a pop this cycle does not
  // free room for a push in the same cycle.
  assign in_inv_ready       = rst_n & (count_q != FULL_CNT);
  assign in_inv_outstanding = (count_q != '0);
  assign out_inv_valid      = (state_q == ST_REQ);
  assign out_inv_addr       = out_addr_q;

`ifdef ICACHE_INV_QUEUE_MERGE_EN
  logic [PTR_W-1:0] idx;

  // The issued head is skipped: the cache may already be past that line,
  // so a fresh request for it must still be replayed.
  always_comb begin
    merge_hit = 1'b0;
    idx       = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_q + PTR_W'(k);
      if ((CNT_W'(k) < count_q) && !((k == 0) && (state_q != ST_IDLE)) &&
          (mem_q[idx] == in_inv_addr)) begin
        merge_hit = 1'b1;
      end
    end
  end
`else
  assign merge_hit = 1'b0;
`endif

  always_comb begin
    push       = in_inv_valid & in_inv_ready & ~merge_hit;
    pop        = out_inv_completed & ((state_q == ST_REQ) | (state_q == ST_WAIT));
    wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d    = count_q;
    state_d    = state_q;
    out_addr_d = out_addr_q;

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      ST_IDLE: begin
        if (count_q != '0) begin
          out_addr_d = mem_q[rd_ptr_q];
          state_d    = ST_REQ;
        end
      end
      ST_REQ:  state_d = out_inv_completed ? ST_IDLE : ST_WAIT;
      ST_WAIT: if (out_inv_completed) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_inv_addr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= ST_IDLE;
      out_addr_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      out_addr_q <= out_addr_d;
    end
  end

endmodule

// File: tb/tb_icache_inv_queue.sv
// Testbench for icache_inv_queue: a scoreboard queue holds the addresses
// expected on the issue port, a downstream model answers each issue pulse
// with a completion after a programmable delay.
module tb_icache_inv_queue;

`ifdef ICACHE_INV_QUEUE_MERGE_EN
  localparam bit MERGE = 1'b1;
`else
  localparam bit MERGE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [29:0] in_inv_addr = '0;
  logic        in_inv_valid = 1'b0;
  logic        in_inv_ready;
  logic        in_inv_outstanding;
  logic [29:0] out_inv_addr;
  logic        out_inv_valid;
  logic        out_inv_completed = 1'b0;

  icache_inv_queue #(.DEPTH(4)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .in_inv_addr        (in_inv_addr),
    .in_inv_valid       (in_inv_valid),
    .in_inv_ready       (in_inv_ready),
    .in_inv_outstanding (in_inv_outstanding),
    .out_inv_addr       (out_inv_addr),
    .out_inv_valid      (out_inv_valid),
    .out_inv_completed  (out_inv_completed)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          n_issued = 0;
  int          last_pulse = -1;
  int          acc_cyc = 0;
  int          comp_cnt = 0;
  int          comp_dly = 1;
  bit          auto_comp = 1'b0;
  bit          gap_chk = 1'b0;
  logic [29:0] sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // Downstream model and issue monitor, sampling 1 time unit after each edge.
  initial begin
    logic [29:0] exp_a;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      out_inv_completed = 1'b0;
      if (comp_cnt > 0) begin
        comp_cnt--;
        if (comp_cnt == 0) out_inv_completed = 1'b1;
      end
      if (out_inv_valid) begin
        n_issued++;
        if (sb.size() == 0) chk("unexpected_issue", {2'b0, out_inv_addr}, 32'hFFFF_FFFF);
        else begin
          exp_a = sb.pop_front();
          chk("issue_addr", {2'b0, out_inv_addr}, {2'b0, exp_a});
        end
        if (gap_chk && last_pulse >= 0) chk("issue_gap", cyc - last_pulse, 2);
        last_pulse = cyc;
        if (auto_comp) begin
          if (comp_dly == 0) out_inv_completed = 1'b1;
          else comp_cnt = comp_dly;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push_req(input logic [29:0] a, input bit expect_enq);
    int budget = 200;
    in_inv_addr  = a;
    in_inv_valid = 1'b1;
    while (!in_inv_ready && budget > 0) begin
      wait_cyc(1);
      budget--;
    end
    if (budget == 0) chk("push_timeout", 0, 1);
    acc_cyc = cyc;
    if (expect_enq) sb.push_back(a);
    wait_cyc(1);
    in_inv_valid = 1'b0;
  endtask

  task automatic wait_issue(input int target);
    int budget = 100;
    while (n_issued < target && budget > 0) begin
      wait_cyc(1);
      budget--;
    end
    if (budget == 0) chk("issue_timeout", n_issued, target);
  endtask

  task automatic drain(input int target);
    int budget = 500;
    while ((n_issued < target || in_inv_outstanding) && budget > 0) begin
      wait_cyc(1);
      budget--;
    end
    if (budget == 0) chk("drain_timeout", n_issued, target);
    chk("sb_empty", sb.size(), 0);
  endtask

  initial begin
    int n0;
    int p;

    // Reset values while held in reset
    #12;
    chk("rst_ready", in_inv_ready, 0);
    chk("rst_valid", out_inv_valid, 0);
    chk("rst_addr", out_inv_addr, 0);
    chk("rst_outstanding", in_inv_outstanding, 0);
    wait_cyc(2);
    rst_n = 1'b1;
    #1;
    chk("ready_after_rst", in_inv_ready, 1);
    wait_cyc(1);

    // Single request: issue two cycles after accept, outstanding drops after completion
    auto_comp = 1'b1;
    comp_dly  = 3;
    n0 = n_issued;
    push_req(30'h40, 1'b1);
    wait_issue(n0 + 1);
    p = last_pulse;
    chk("single_latency", p - acc_cyc, 2);
    wait_cyc(3);
    chk("single_outst_at_compl", in_inv_outstanding, 1);
    wait_cyc(1);
    chk("single_outst_after", in_inv_outstanding, 0);
    drain(n0 + 1);

    // Fill to full, hold a fifth request until the first completes
    auto_comp = 1'b0;
    n0 = n_issued;
    for (int i = 1; i <= 4; i++) push_req(30'(i), 1'b1);
    chk("full_ready", in_inv_ready, 0);
    chk("full_outstanding", in_inv_outstanding, 1);
    fork
      push_req(30'h5, 1'b1);
      begin
        wait_cyc(3);
        chk("full_held_ready", in_inv_ready, 0);
        chk("full_held_valid", in_inv_valid, 1);
        auto_comp = 1'b1;
        comp_dly  = 1;
        out_inv_completed = 1'b1;
      end
    join
    drain(n0 + 5);

    // Same-cycle completion: no WAIT, next pulse two cycles later
    comp_dly   = 0;
    gap_chk    = 1'b1;
    last_pulse = -1;
    n0 = n_issued;
    for (int i = 0; i < 3; i++) push_req(30'h30 + 30'(i), 1'b1);
    drain(n0 + 3);
    gap_chk = 1'b0;

    // Wrap-around: ten requests, completion two cycles after each pulse
    comp_dly = 2;
    n0 = n_issued;
    for (int i = 0; i < 10; i++) push_req(30'h10 + 30'(i), 1'b1);
    drain(n0 + 10);
    chk("wrap_count", n_issued - n0, 10);

    // Reset while waiting for completion with three entries queued
    auto_comp = 1'b0;
    n0 = n_issued;
    for (int i = 0; i < 3; i++) push_req(30'h50 + 30'(i), 1'b1);
    wait_issue(n0 + 1);
    wait_cyc(1);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", out_inv_valid, 0);
    chk("midrst_addr", out_inv_addr, 0);
    chk("midrst_ready", in_inv_ready, 0);
    chk("midrst_outstanding", in_inv_outstanding, 0);
    sb.delete();
    wait_cyc(1);
    rst_n = 1'b1;
    #1;
    chk("midrst_ready_rel", in_inv_ready, 1);
    out_inv_completed = 1'b1;
    n0 = n_issued;
    wait_cyc(5);
    chk("late_compl_no_issue", n_issued - n0, 0);
    chk("late_compl_outst", in_inv_outstanding, 0);
    auto_comp = 1'b1;
    comp_dly  = 1;
    push_req(30'h60, 1'b1);
    drain(n0 + 1);

    // Duplicate handling: in-flight 0x20, pending 0x21, then push 0x21 and 0x20
    auto_comp = 1'b0;
    n0 = n_issued;
    push_req(30'h20, 1'b1);
    wait_issue(n0 + 1);
    push_req(30'h21, 1'b1);
    push_req(30'h21, !MERGE);
    push_req(30'h20, 1'b1);
    chk("dup_ready", in_inv_ready, MERGE);
    chk("dup_outstanding", in_inv_outstanding, 1);
    auto_comp = 1'b1;
    comp_dly  = 1;
    out_inv_completed = 1'b1;
    drain(n0 + (MERGE ? 3 : 4));
    chk("dup_issue_count", n_issued - n0, MERGE ? 3 : 4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
